// File: rtl/sid_adsr_mux.sv
// Time-multiplexed SID-style ADSR envelope for NUM_VOICES voices; voice v is updated in prescaler slot v.
// Level registered one clk after its slot; no backpressure, en_i low freezes prescaler and all voice state.
module sid_adsr_mux #(
   parameter int NUM_VOICES = 3,
   parameter int CLK_DIV    = 24,
   parameter int RATE_W     = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic [NUM_VOICES-1:0]   gate_i,
   input  logic [4*NUM_VOICES-1:0] attack_i,
   input  logic [4*NUM_VOICES-1:0] decay_i,
   input  logic [4*NUM_VOICES-1:0] sustain_i,
   input  logic [4*NUM_VOICES-1:0] release_i,
   output logic [8*NUM_VOICES-1:0] env_out_o,
   output logic [2*NUM_VOICES-1:0] env_state_o
);

   localparam int PSC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST   = PSC_W'(CLK_DIV - 1);
   localparam logic [PSC_W-1:0] VOICE_LAST = PSC_W'(NUM_VOICES - 1);

   if (NUM_VOICES < 1) begin : g_chk_voices
      $error("sid_adsr_mux: NUM_VOICES must be >= 1");
   end
   if (CLK_DIV < NUM_VOICES) begin : g_chk_div
      $error("sid_adsr_mux: CLK_DIV must be >= NUM_VOICES");
   end
   if (RATE_W < 15) begin : g_chk_rate
      $error("sid_adsr_mux: RATE_W too narrow for the longest rate period");
   end

   typedef enum logic [1:0] {
      ST_RELEASE   = 2'd0,
      ST_ATTACK    = 2'd1,
      ST_DECAY_SUS = 2'd2
   } env_st_e;

   // Rate table stored as period-1 so the counter compares directly against it.
   function automatic logic [RATE_W-1:0] period_m1(input logic [3:0] idx);
      case (idx)
         4'd0:    period_m1 = RATE_W'(8);
         4'd1:    period_m1 = RATE_W'(31);
         4'd2:    period_m1 = RATE_W'(62);
         4'd3:    period_m1 = RATE_W'(94);
         4'd4:    period_m1 = RATE_W'(148);
         4'd5:    period_m1 = RATE_W'(219);
         4'd6:    period_m1 = RATE_W'(266);
         4'd7:    period_m1 = RATE_W'(312);
         4'd8:    period_m1 = RATE_W'(391);
         4'd9:    period_m1 = RATE_W'(976);
         4'd10:   period_m1 = RATE_W'(1953);
         4'd11:   period_m1 = RATE_W'(3125);
         4'd12:   period_m1 = RATE_W'(3906);
         4'd13:   period_m1 = RATE_W'(11719);
         4'd14:   period_m1 = RATE_W'(19531);
         default: period_m1 = RATE_W'(31250);
      endcase
   endfunction

   function automatic logic [4:0] exp_div_m1(input logic [7:0] lvl);
      if (lvl > 8'h5D)      exp_div_m1 = 5'd0;
      else if (lvl > 8'h36) exp_div_m1 = 5'd1;
      else if (lvl > 8'h1A) exp_div_m1 = 5'd3;
      else if (lvl > 8'h0E) exp_div_m1 = 5'd7;
      else if (lvl > 8'h06) exp_div_m1 = 5'd15;
      else                  exp_div_m1 = 5'd29;
   endfunction

   logic [PSC_W-1:0]  psc_q, psc_d;
   logic [7:0]        env_q   [NUM_VOICES];
   env_st_e           st_q    [NUM_VOICES];
   logic [RATE_W-1:0] rate_q  [NUM_VOICES];
   logic [4:0]        exp_q   [NUM_VOICES];
   logic [NUM_VOICES-1:0] gprev_q;

   logic [3:0] atk_v [NUM_VOICES];
   logic [3:0] dcy_v [NUM_VOICES];
   logic [3:0] sus_v [NUM_VOICES];
   logic [3:0] rel_v [NUM_VOICES];

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_io
      assign atk_v[g] = attack_i[4*g +: 4];
      assign dcy_v[g] = decay_i[4*g +: 4];
      assign sus_v[g] = sustain_i[4*g +: 4];
      assign rel_v[g] = release_i[4*g +: 4];
      assign env_out_o[8*g +: 8]   = env_q[g];
      assign env_state_o[2*g +: 2] = st_q[g];
   end

   logic              slot_vld;
   logic [VID_W-1:0]  cur_v;
   logic              gate_cur, gprev_cur;
   logic [7:0]        env_cur, env_d, sus_lvl;
   env_st_e           st_cur, st_d;
   logic [RATE_W-1:0] rate_cur, rate_d, per_m1;
   logic [4:0]        exp_cur, exp_d;
   logic              rate_wrap, exp_hit;

   assign slot_vld = en_i && (psc_q <= VOICE_LAST);
   assign cur_v    = VID_W'(psc_q);

   always_comb begin
      psc_d = psc_q;
      if (en_i) begin
         psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
      end
   end

   // Shared per-slot datapath: the selected voice's state is read, advanced and written back.
   always_comb begin
      gate_cur  = gate_i[cur_v];
      gprev_cur = gprev_q[cur_v];
      env_cur   = env_q[cur_v];
      st_cur    = st_q[cur_v];
      rate_cur  = rate_q[cur_v];
      exp_cur   = exp_q[cur_v];
      sus_lvl   = {sus_v[cur_v], sus_v[cur_v]};
      per_m1    = period_m1(rel_v[cur_v]);
      case (st_cur)
         ST_ATTACK:    per_m1 = period_m1(atk_v[cur_v]);
         ST_DECAY_SUS: per_m1 = period_m1(dcy_v[cur_v]);
         default:      per_m1 = period_m1(rel_v[cur_v]);
      endcase
      rate_wrap = (rate_cur == per_m1);
      exp_hit   = (st_cur == ST_ATTACK) || (exp_cur == exp_div_m1(env_cur));

      env_d  = env_cur;
      st_d   = st_cur;
      rate_d = rate_cur;
      exp_d  = exp_cur;

      if (gate_cur != gprev_cur) begin
         st_d   = gate_cur ? ST_ATTACK : ST_RELEASE;
         rate_d = '0;
         exp_d  = '0;
      end else if (rate_wrap) begin
         rate_d = '0;
         if (!exp_hit) begin
            exp_d = exp_cur + 5'd1;
         end else begin
            exp_d = '0;
            case (st_cur)
               ST_ATTACK: begin
                  if (env_cur != 8'hFF) env_d = env_cur + 8'd1;
                  if (env_cur >= 8'hFE) st_d = ST_DECAY_SUS;
               end
               ST_DECAY_SUS: begin
                  if (env_cur > sus_lvl) env_d = env_cur - 8'd1;
               end
               default: begin
                  if (env_cur != 8'h00) env_d = env_cur - 8'd1;
               end
            endcase
         end
      end else begin
         // Counter above a freshly shortened period runs on to 2^RATE_W before wrapping.
         rate_d = rate_cur + RATE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q   <= '0;
         gprev_q <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            env_q[v]  <= '0;
            st_q[v]   <= ST_RELEASE;
            rate_q[v] <= '0;
            exp_q[v]  <= '0;
         end
      end else begin
         psc_q <= psc_d;
         if (slot_vld) begin
            env_q[cur_v]   <= env_d;
            st_q[cur_v]    <= st_d;
            rate_q[cur_v]  <= rate_d;
            exp_q[cur_v]   <= exp_d;
            gprev_q[cur_v] <= gate_cur;
         end
      end
   end

endmodule

// File: tb/tb_sid_adsr_mux.sv
// Bench for sid_adsr_mux: directed ADSR walk on voice 0 plus randomised multi-voice traffic,
// every cycle compared against a per-slot model that tracks elapsed slots since the last step.
module tb_sid_adsr_mux;
   localparam int NV = 3;
   localparam int CD = 4;
   localparam int RW = 15;
   localparam int ST_REL = 0;
   localparam int ST_ATK = 1;
   localparam int ST_DS  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [NV-1:0]   gate;
   logic [4*NV-1:0] atk, dcy, sus, rel;
   logic [8*NV-1:0] env_out;
   logic [2*NV-1:0] env_state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int per_tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251};
   int m_env [NV];
   int m_st  [NV];
   int m_el  [NV];
   bit m_gp  [NV];
   int m_ph;

   string env_tag [NV];
   string st_tag  [NV];

   bit         watch = 1'b0;
   logic [7:0] w_prev_env;
   logic [1:0] w_prev_st;
   int         w_last;

   always #5 clk = ~clk;

   sid_adsr_mux #(.NUM_VOICES(NV), .CLK_DIV(CD), .RATE_W(RW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en),
      .gate_i      (gate),
      .attack_i    (atk),
      .decay_i     (dcy),
      .sustain_i   (sus),
      .release_i   (rel),
      .env_out_o   (env_out),
      .env_state_o (env_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int exp_div(input int e);
      if (e > 'h5D) return 1;
      if (e > 'h36) return 2;
      if (e > 'h1A) return 4;
      if (e > 'h0E) return 8;
      if (e > 'h06) return 16;
      return 30;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_env[v] = 0;
         m_st[v]  = ST_REL;
         m_el[v]  = 0;
         m_gp[v]  = 1'b0;
      end
      m_ph = 0;
   endtask

   task automatic model_slot(input int v);
      bit g;
      int tgt;
      g = gate[v];
      if (g != m_gp[v]) begin
         m_gp[v] = g;
         m_st[v] = g ? ST_ATK : ST_REL;
         m_el[v] = 0;
      end else begin
         if (m_st[v] == ST_ATK)     tgt = per_tab[atk[4*v +: 4]];
         else if (m_st[v] == ST_DS) tgt = per_tab[dcy[4*v +: 4]] * exp_div(m_env[v]);
         else                       tgt = per_tab[rel[4*v +: 4]] * exp_div(m_env[v]);
         m_el[v]++;
         if (m_el[v] == tgt) begin
            m_el[v] = 0;
            if (m_st[v] == ST_ATK) begin
               if (m_env[v] < 255) m_env[v]++;
               if (m_env[v] == 255) m_st[v] = ST_DS;
            end else if (m_st[v] == ST_DS) begin
               if (m_env[v] > int'(sus[4*v +: 4]) * 17) m_env[v]--;
            end else begin
               if (m_env[v] > 0) m_env[v]--;
            end
         end
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else if (en) begin
         if (m_ph < NV) model_slot(m_ph);
         m_ph = (m_ph + 1) % CD;
      end
   endtask

   // Expected clks between consecutive voice-0 steps at a few landmark levels.
   function automatic int landmark_iv(input logic [1:0] st, input logic [7:0] e);
      if (st == 2'(ST_ATK) && e == 8'h80) return 9 * CD;
      if (st == 2'(ST_DS)  && e == 8'hC0) return 9 * CD;
      if (st == 2'(ST_DS)  && e == 8'h58) return 18 * CD;
      if (st == 2'(ST_REL) && e == 8'h54) return 18 * CD;
      if (st == 2'(ST_REL) && e == 8'h30) return 36 * CD;
      if (st == 2'(ST_REL) && e == 8'h15) return 72 * CD;
      if (st == 2'(ST_REL) && e == 8'h0A) return 144 * CD;
      if (st == 2'(ST_REL) && e == 8'h03) return 270 * CD;
      return 0;
   endfunction

   task automatic watch_v0();
      int iv;
      if (env_out[7:0] != w_prev_env) begin
         iv = landmark_iv(w_prev_st, w_prev_env);
         if (iv != 0) check_eq($sformatf("step_iv_%02h", w_prev_env), cyc - w_last, iv);
         w_last = cyc;
      end
      w_prev_env = env_out[7:0];
      w_prev_st  = env_state[1:0];
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      for (int v = 0; v < NV; v++) begin
         check_eq(env_tag[v], env_out[8*v +: 8], m_env[v]);
         check_eq(st_tag[v], env_state[2*v +: 2], m_st[v]);
      end
      if (watch) watch_v0();
   endtask

   task automatic wait_env0(input logic [7:0] val, input int budget, input string tag);
      int n = 0;
      while (env_out[7:0] !== val && n < budget) begin
         cycle();
         n++;
      end
      check_eq(tag, env_out[7:0], val);
   endtask

   task automatic wait_st0(input logic [1:0] val, input int budget, input string tag);
      int n = 0;
      while (env_state[1:0] !== val && n < budget) begin
         cycle();
         n++;
      end
      check_eq(tag, env_state[1:0], val);
   endtask

   task automatic retune(input int v);
      gate[v]        = ~gate[v];
      atk[4*v +: 4]  = 4'($urandom_range(1));
      dcy[4*v +: 4]  = 4'($urandom_range(2));
      rel[4*v +: 4]  = 4'($urandom_range(2));
   endtask

   initial begin
      int t0;
      int sv;
      for (int v = 0; v < NV; v++) begin
         env_tag[v] = $sformatf("env%0d", v);
         st_tag[v]  = $sformatf("state%0d", v);
      end
      rst_n = 1'b0;
      en    = 1'b0;
      gate  = '0;
      atk   = '0;
      dcy   = '0;
      sus   = '0;
      rel   = '0;
      model_reset();
      repeat (10) cycle();
      check_eq("rst_env", env_out, 0);
      check_eq("rst_state", env_state, 0);

      rst_n     = 1'b1;
      en        = 1'b1;
      sus[3:0]  = 4'hA;
      gate[0]   = 1'b1;
      w_prev_env = 8'h00;
      w_prev_st  = 2'(ST_REL);
      w_last     = cyc;
      watch      = 1'b1;

      // Asynchronous reset in the middle of an attack.
      wait_env0(8'h40, 64 * 9 * CD + 50, "atk_to_40");
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_env", env_out, 0);
      check_eq("arst_state", env_state, 0);
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;

      wait_st0(2'(ST_ATK), 8, "atk_start");
      t0 = cyc;
      wait_env0(8'hFF, 2295 * CD + 100, "atk_to_ff");
      check_eq("atk_clks", cyc - t0, 2295 * CD);
      check_eq("atk_done_state", env_state[1:0], ST_DS);
      check_eq("v12_idle", env_out[8*NV-1:8], 0);

      wait_env0(8'hAA, 85 * 9 * CD + 100, "decay_to_aa");
      repeat (500 * CD) cycle();
      check_eq("sus_hold", env_out[7:0], 8'hAA);
      sus[3:0] = 4'h5;
      wait_env0(8'h55, (77 * 9 + 8 * 18) * CD + 100, "decay_to_55");

      gate[0] = 1'b0;
      wait_env0(8'h00, 5202 * CD + 500, "release_to_0");
      repeat (400) cycle();
      check_eq("rel_floor", env_out[7:0], 8'h00);
      check_eq("rel_state", env_state[1:0], ST_REL);

      gate[0] = 1'b1;
      wait_env0(8'h50, 80 * 9 * CD + 100, "re_rise");
      gate[0] = 1'b0;
      wait_env0(8'h40, 16 * 18 * CD + 100, "re_fall");
      gate[0] = 1'b1;
      wait_st0(2'(ST_ATK), 8, "re_attack");
      check_eq("re_level", env_out[7:0], 8'h40);
      t0 = cyc;
      wait_env0(8'h41, 9 * CD + 10, "re_step");
      check_eq("re_clks", cyc - t0, 9 * CD);
      watch = 1'b0;

      // Randomised multi-voice traffic with an extended en-low window.
      for (int k = 0; k < 24000; k++) begin
         if (k == 12000) begin
            en = 1'b0;
            repeat (100) cycle();
            gate[2] = ~gate[2];
            repeat (400) cycle();
            gate[2] = ~gate[2];
            repeat (500) cycle();
         end
         for (int v = 0; v < NV; v++) begin
            if (k == v * 400 || $urandom_range(2999) == 0) retune(v);
         end
         if ($urandom_range(1999) == 0) begin
            sv = $urandom_range(NV - 1);
            sus[4*sv +: 4] = 4'($urandom_range(15));
         end
         en = ($urandom_range(39) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
